// File: rtl/conv_stream_kxk_pkg.sv
// Shared constants and width helpers for the streaming KxK convolution.
package conv_stream_kxk_pkg;
  localparam int PIX_W   = 8;
  localparam int WW_DEF  = 8;
  localparam int SHIFT_W = 4;
  localparam int RELU_LO = 0;
  localparam int RELU_HI = 255;
  localparam int SAT_LO  = -128;
  localparam int SAT_HI  = 127;

  // Accumulator wide enough that K*K full-scale products plus bias never wrap.
  function automatic int acc_w(input int k, input int ww);
    return ww + PIX_W + 1 + $clog2(k * k);
  endfunction
endpackage

// File: rtl/conv_stream_kxk_if.sv
// Pixel-in / result-out valid-ready stream bundle for conv_stream_kxk.
interface conv_stream_kxk_if;
  import conv_stream_kxk_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] pxl_in;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pxl_out;
  logic             out_last;

  modport master (
    output in_valid, pxl_in, out_ready,
    input  in_ready, out_valid, pxl_out, out_last
  );

  modport slave (
    input  in_valid, pxl_in, out_ready,
    output in_ready, out_valid, pxl_out, out_last
  );
endinterface

// File: rtl/conv_stream_kxk_line_buf.sv
// One image row of delay: a DEPTH-entry shift line that advances only when en is set.
module line_buf #(
  parameter int DEPTH = 28,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  // Contents are don't-care after reset; frame tags mask stale rows.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/conv_stream_kxk.sv
// Streaming KxK valid-mode convolution: line buffers + window, MAC tree with bias,
// shift and ReLU/saturate clip, three adv-gated stages under valid/ready flow control.
module conv_stream_kxk import conv_stream_kxk_pkg::*; #(
  parameter int K  = 5,
  parameter int N  = 28,
  parameter int M  = 28,
  parameter int WW = WW_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  conv_stream_kxk_if.slave                strm,
  output logic                            busy,
  input  logic                            wt_we,
  input  logic [$clog2(K*K)-1:0]          wt_addr,
  input  logic signed [WW-1:0]            wt_data,
  input  logic signed [acc_w(K, WW)-1:0]  cfg_bias,
  input  logic [SHIFT_W-1:0]              cfg_shift,
  input  logic                            cfg_relu
);
  localparam int NW     = K * K;
  localparam int AW     = $clog2(NW);
  localparam int ACC_W  = acc_w(K, WW);
  localparam int PROD_W = WW + PIX_W + 1;
  localparam int COL_W  = $clog2(N);
  localparam int ROW_W  = $clog2(M);
  localparam int NL     = 1 << $clog2(NW);
  localparam logic signed [ACC_W-1:0] RELU_LO_A = ACC_W'(RELU_LO);
  localparam logic signed [ACC_W-1:0] RELU_HI_A = ACC_W'(RELU_HI);
  localparam logic signed [ACC_W-1:0] SAT_LO_A  = ACC_W'(SAT_LO);
  localparam logic signed [ACC_W-1:0] SAT_HI_A  = ACC_W'(SAT_HI);

  logic                      adv, acc;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [PIX_W-1:0]          win_q [K][K];
  logic [PIX_W-1:0]          win_d [K][K];
  logic [K-1:0][PIX_W-1:0]   tap;
  logic signed [WW-1:0]      wt_q [NW];
  logic signed [WW-1:0]      wt_d [NW];
  logic                      s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic                      s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d, shifted;
  logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [PIX_W-1:0]          pxl_out_q, pxl_out_d, pxl_clip;
  logic signed [PROD_W-1:0]  prod [NW];
  logic signed [ACC_W-1:0]   node [2*NL-1];

  assign adv            = !out_valid_q || strm.out_ready;
  assign acc            = strm.in_valid && adv;
  assign strm.in_ready  = adv;
  assign strm.out_valid = out_valid_q;
  assign strm.pxl_out   = pxl_out_q;
  assign strm.out_last  = out_last_q;
  assign busy = (row_q != '0) || (col_q != '0) || s1_valid_q || s2_valid_q || out_valid_q;

  // tap[j] is the pixel j rows above the incoming one, same column.
  assign tap[0] = strm.pxl_in;
  for (genvar j = 1; j < K; j++) begin : g_lb
    line_buf #(.DEPTH(N), .W(PIX_W)) u_lb (
      .clk  (clk),
      .en   (acc),
      .din  (tap[j-1]),
      .dout (tap[j])
    );
  end

  // Heap-indexed adder tree; leaves beyond K*K are padded with zero.
  for (genvar i = 0; i < NL; i++) begin : g_leaf
    if (i < NW) begin : g_prod
      assign prod[i] = PROD_W'(wt_q[i]) * PROD_W'($signed({1'b0, win_q[i / K][i % K]}));
      assign node[NL-1+i] = ACC_W'(prod[i]);
    end else begin : g_pad
      assign node[NL-1+i] = '0;
    end
  end
  for (genvar i = 0; i < NL - 1; i++) begin : g_tree
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  always_comb begin
    shifted = sum_q >>> cfg_shift;
    if (cfg_relu) begin
      if (shifted < RELU_LO_A)      pxl_clip = PIX_W'(RELU_LO);
      else if (shifted > RELU_HI_A) pxl_clip = PIX_W'(RELU_HI);
      else                          pxl_clip = shifted[PIX_W-1:0];
    end else begin
      if (shifted < SAT_LO_A)       pxl_clip = PIX_W'(SAT_LO);
      else if (shifted > SAT_HI_A)  pxl_clip = PIX_W'(SAT_HI);
      else                          pxl_clip = shifted[PIX_W-1:0];
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    wt_d        = wt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pxl_out_d   = pxl_out_q;
    if (adv) begin
      s1_valid_d  = acc && (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
      s1_last_d   = acc && (row_q == ROW_W'(M-1)) && (col_q == COL_W'(N-1));
      s2_valid_d  = s1_valid_q;
      s2_last_d   = s1_last_q;
      sum_d       = node[0] + cfg_bias;
      out_valid_d = s2_valid_q;
      out_last_d  = s2_last_q;
      pxl_out_d   = pxl_clip;
    end
    if (acc) begin
      if (col_q == COL_W'(N-1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(M-1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      for (int kr = 0; kr < K; kr++) begin
        for (int kc = 0; kc < K - 1; kc++) win_d[kr][kc] = win_q[kr][kc+1];
        win_d[kr][K-1] = tap[K-1-kr];
      end
    end
    // Idle-only writes keep weights coherent for every window of a frame.
    if (wt_we && !busy) begin
      for (int i = 0; i < NW; i++) begin
        if (wt_addr == AW'(i)) wt_d[i] = wt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      wt_q        <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pxl_out_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      wt_q        <= wt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pxl_out_q   <= pxl_out_d;
    end
  end

  always_ff @(posedge clk) win_q <= win_d;
endmodule

// File: tb/tb_conv_stream_kxk.sv
// Bench for conv_stream_kxk (K=3, 5x5): directed cases plus randomized frames checked
// against a per-window arithmetic model through an in-order result queue.
module tb_conv_stream_kxk;
  import conv_stream_kxk_pkg::*;

  localparam int K = 3, N = 5, M = 5, NW = K * K;
  localparam int ACC_W = acc_w(K, 8);

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    busy;
  logic                    wt_we;
  logic [3:0]              wt_addr;
  logic signed [7:0]       wt_data;
  logic signed [ACC_W-1:0] cfg_bias;
  logic [3:0]              cfg_shift;
  logic                    cfg_relu;

  conv_stream_kxk_if sif ();

  conv_stream_kxk #(.K(K), .N(N), .M(M), .WW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .strm      (sif),
    .busy      (busy),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .cfg_bias  (cfg_bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu)
  );

  always #5 clk = ~clk;

  typedef struct {int px; bit last;} exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int total = 0, bad = 0;
  int recv_cnt = 0, last_seen = 0, low_cnt = 0, stall_cnt = 0;
  bit mon_en = 0, stall_arm = 0, rnd_rdy = 0, hold_pend = 0, hold_last;
  int hold_px;
  int mw[NW];
  int m_bias = 0, m_shift = 0;
  bit m_relu = 1;
  int img[M][N];

  function automatic void chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endfunction

  // Reference: one valid-mode window ending at (r,c), straight from the arithmetic rules.
  function automatic int conv_at(input int r, input int c);
    int s;
    s = m_bias;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        s += mw[kr*K+kc] * img[r-K+1+kr][c-K+1+kc];
    s = s >>> m_shift;
    if (m_relu) return (s < 0) ? 0 : (s > 255) ? 255 : s;
    if (s < -128) s = -128;
    if (s > 127) s = 127;
    return s & 255;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = K - 1; r < M; r++)
      for (int c = K - 1; c < N; c++) begin
        e.px = conv_at(r, c);
        e.last = (r == M - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic set_cfg(input int b, input int s, input bit r);
    m_bias = b; m_shift = s; m_relu = r;
    cfg_bias = ACC_W'(b); cfg_shift = 4'(s); cfg_relu = r;
  endtask

  task automatic write_w(input int a, input int d);
    wt_we = 1'b1; wt_addr = 4'(a); wt_data = 8'(d);
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic load_mw();
    for (int i = 0; i < NW; i++) write_w(i, mw[i]);
  endtask

  task automatic fill_ramp(input int off);
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) img[r][c] = 5 * r + c + off;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) img[r][c] = int'($urandom_range(255));
  endtask

  // wa >= 0 pulses a weight write in the same cycle as the first pixel.
  task automatic send_frame(input int npix, input int gap_pct, input int wa, input int wd);
    bit ok;
    int tmo;
    if (npix == M * N) begin
      if (wa >= 0 && wa < NW) mw[wa] = wd;
      push_frame();
    end
    for (int i = 0; i < npix; i++) begin
      if (gap_pct > 0)
        while (int'($urandom_range(99)) < gap_pct) begin
          sif.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      sif.in_valid = 1'b1;
      sif.pxl_in = 8'(img[i / N][i % N]);
      if (i == 0 && wa >= 0) begin wt_we = 1'b1; wt_addr = 4'(wa); wt_data = 8'(wd); end
      ok = 0; tmo = 0;
      while (!ok) begin
        @(negedge clk); ok = sif.in_ready;
        @(posedge clk); #1;
        if (i == 0 && wa >= 0) wt_we = 1'b0;
        tmo++;
        if (!ok && tmo > 300) begin
          $display("FAIL send_timeout: pixel %0d not accepted in %0d cycles, want accept", i, tmo);
          $fatal(1, "input stalled");
        end
      end
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin @(posedge clk); #1; t++; end
    chk({nm, "_drain"}, int'(t < 1000), 1);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset = 1'b1; sif.in_valid = 1'b0; wt_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); hold_pend = 0;
    for (int i = 0; i < NW; i++) mw[i] = 0;
    @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 1);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_pxl_out", sif.pxl_out, 0);
    chk("rst_out_last", sif.out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        sif.out_ready = 1'b0; stall_cnt--;
      end else if (stall_arm && sif.out_valid) begin
        sif.out_ready = 1'b0; stall_cnt = 2; stall_arm = 0;
      end else begin
        sif.out_ready = rnd_rdy ? ($urandom_range(99) < 60) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready_rule", sif.in_ready, int'(!sif.out_valid || sif.out_ready));
      if (hold_pend) begin
        chk("hold_valid", sif.out_valid, 1);
        chk("hold_px", sif.pxl_out, hold_px);
        chk("hold_last", sif.out_last, hold_last);
      end
      if (!sif.in_ready) low_cnt++;
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got px %0d, want no result", sif.pxl_out);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_px", sif.pxl_out, e_mon.px);
          chk("out_last", sif.out_last, e_mon.last);
        end
        recv_cnt++;
        if (sif.out_last) last_seen++;
      end
      hold_pend = sif.out_valid && !sif.out_ready;
      hold_px = sif.pxl_out;
      hold_last = sif.out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, l0, t;
    int ident[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    sif.in_valid = 1'b0; sif.pxl_in = '0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    set_cfg(0, 0, 1);
    do_reset();

    // Identity via centre tap, loaded in the first-pixel cycle.
    fill_ramp(0);
    r0 = recv_cnt; l0 = last_seen;
    send_frame(M * N, 0, 4, 1);
    wait_drain("t1");
    chk("t1_count", recv_cnt - r0, 9);
    chk("t1_lasts", last_seen - l0, 1);
    for (int i = 0; i < 9; i++) chk("pin_t1", conv_at(2 + i / 3, 2 + i % 3), ident[i]);

    // Output back-pressure mid-frame.
    low_cnt = 0; r0 = recv_cnt;
    fork
      send_frame(M * N, 0, -1, 0);
      begin
        t = 0;
        while (recv_cnt < r0 + 3 && t < 500) begin @(posedge clk); t++; end
        chk("t4_arm", int'(t < 500), 1);
        stall_arm = 1;
      end
    join
    wait_drain("t4");
    chk("t4_in_ready_low", low_cnt, 3);
    chk("t4_count", recv_cnt - r0, 9);

    // All-ones weights on a saturated image.
    for (int i = 0; i < NW; i++) mw[i] = 1;
    load_mw();
    fill_const(255);
    set_cfg(0, 0, 1); chk("pin_t2_s0", conv_at(2, 2), 255);
    send_frame(M * N, 0, -1, 0); wait_drain("t2a");
    set_cfg(0, 4, 1); chk("pin_t2_s4", conv_at(2, 2), 143);
    send_frame(M * N, 0, -1, 0); wait_drain("t2b");
    set_cfg(0, 3, 1); chk("pin_t2_s3", conv_at(2, 2), 255);
    send_frame(M * N, 0, -1, 0); wait_drain("t2c");

    // Negative weights: ReLU floor and signed saturation.
    for (int i = 0; i < NW; i++) mw[i] = -1;
    load_mw();
    fill_const(1);
    set_cfg(0, 0, 1); chk("pin_t3_relu", conv_at(2, 2), 0);
    send_frame(M * N, 0, -1, 0); wait_drain("t3a");
    set_cfg(0, 0, 0); chk("pin_t3_sat", conv_at(2, 2), 247);
    send_frame(M * N, 0, -1, 0); wait_drain("t3b");
    fill_const(255); chk("pin_t3_clamp", conv_at(2, 2), 128);
    send_frame(M * N, 0, -1, 0); wait_drain("t3c");

    // Reset mid-frame clears counters and weights.
    for (int i = 0; i < NW; i++) mw[i] = 0;
    mw[4] = 1;
    load_mw();
    set_cfg(0, 0, 1);
    fill_ramp(0);
    send_frame(7, 0, -1, 0);
    do_reset();
    set_cfg(40, 0, 1);
    chk("pin_t5_zero_w", conv_at(2, 2), 40);
    send_frame(M * N, 0, -1, 0); wait_drain("t5z");
    set_cfg(0, 0, 1);
    mw[4] = 1;
    load_mw();
    for (int a = NW; a < 16; a++) write_w(a, 99);
    r0 = recv_cnt;
    fork
      send_frame(M * N, 0, -1, 0);
      begin repeat (8) @(posedge clk); #1; write_w(0, 77); end
    join
    wait_drain("t5");
    chk("t5_count", recv_cnt - r0, 9);

    // Back-to-back frames.
    r0 = recv_cnt; l0 = last_seen;
    fill_ramp(0);  send_frame(M * N, 0, -1, 0);
    fill_ramp(50); send_frame(M * N, 0, -1, 0);
    wait_drain("t6");
    chk("t6_count", recv_cnt - r0, 18);
    chk("t6_lasts", last_seen - l0, 2);

    // Randomized weights, config, images, input gaps and output stalls.
    rnd_rdy = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NW; i++) mw[i] = int'($urandom_range(255)) - 128;
      load_mw();
      set_cfg(int'($urandom_range(6000)) - 3000, int'($urandom_range(10)), 1'($urandom_range(1)));
      fill_rand();
      send_frame(M * N, 30, -1, 0);
      if (f % 2 == 1) begin
        fill_rand();
        send_frame(M * N, 0, -1, 0);
      end
      wait_drain("rnd");
    end
    rnd_rdy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
